vga_sync_gen: RTL and testbench
===============================

// Module: vga_sync_gen
// PURPOSE
//  Produces VGA 640x480@60 timing: horizontal/vertical counters Qh/Qv, active-region flags H_ON/V_ON,
//  and the hsync/vsync pins. Drives the pixel-colour stage that consumes Qh, Qv, H_ON and V_ON.
//  Counters advance once per pixel tick, which is derived from the system clock. Porch order per line
//  and per frame is back porch, active, front porch, sync.
// PARAMETERS
//  PIX_DIV  4   system clocks per pixel (100 MHz -> 25 MHz); must be >=1
//  H_BP     48  horizontal back porch, in pixels (Qh 0..47)
//  H_ACT    640 horizontal active pixels (Qh 48..687)
//  H_FP     16  horizontal front porch (Qh 688..703)
//  H_SYN    96  hsync width (Qh 704..799); H_TOT = sum = 800
//  V_BP     33  vertical back porch, in lines (Qv 0..32)
//  V_ACT    480 active lines (Qv 33..512)
//  V_FP     10  vertical front porch (Qv 513..522)
//  V_SYN    2   vsync width (Qv 523..524); V_TOT = sum = 525
// PORTS
//  reloj     in   1   system clock, 100 MHz
//  resetM    in   1   asynchronous reset, ACTIVE-LOW (one clock; async active-low reset)
//  pix_tick  out  1   one-reloj pulse every PIX_DIV clocks; counters update on this pulse
//  Qh        out  10  horizontal count, 0..H_TOT-1
//  Qv        out  10  vertical count, 0..V_TOT-1
//  H_ON      out  1   1 iff H_BP <= Qh < H_BP+H_ACT
//  V_ON      out  1   1 iff V_BP <= Qv < V_BP+V_ACT
//  hsync     out  1   active-low; 0 iff Qh >= H_TOT-H_SYN
//  vsync     out  1   active-low; 0 iff Qv >= V_TOT-V_SYN
//  fin_cuadro out 1   [VGA_SYNC_FRAME_TICK_EN only] frame-end pulse
// BEHAVIOUR
//  - Reset (resetM=0, async): Qh=0, Qv=0, divider=0, pix_tick=0, H_ON=0, V_ON=0, hsync=1, vsync=1,
//    fin_cuadro=0. Release is synchronised internally through a 2-flop chain, so the first pix_tick
//    occurs PIX_DIV clocks after the second reloj edge following deassertion.
//  - Divider: counts 0..PIX_DIV-1 and wraps. pix_tick is registered and high for the single cycle in
//    which the divider equals PIX_DIV-1. When PIX_DIV=1, pix_tick is held high continuously.
//  - On pix_tick: Qh <= (Qh==H_TOT-1) ? 0 : Qh+1. When Qh wraps, Qv <= (Qv==V_TOT-1) ? 0 : Qv+1.
//    Otherwise Qv holds.
//  - H_ON, V_ON, hsync and vsync are registered and are computed from the next-state counter values.
//    All outputs therefore change on the same reloj edge as Qh/Qv, with zero skew between them.
//  - All outputs are held constant between pix_ticks.
//  - Compares are 10-bit unsigned. Qh/Qv never reach H_TOT/V_TOT. There is no overflow path.
//  - Reset mid-frame: everything returns immediately to the reset values above, and the frame restarts
//    at Qh=0, Qv=0 (back porch).
//  - Frame period = H_TOT*V_TOT*PIX_DIV = 1,680,000 reloj cycles.
// CONFIGURATION
//  - `VGA_SYNC_FRAME_TICK_EN defined: port fin_cuadro exists. It is a one-reloj pulse on the pix_tick at
//    which Qh=H_TOT-1 and Qv=V_TOT-1, i.e. the cycle before the wrap to (0,0). Clock/alarm logic uses it
//    for tear-free updates.
//  - Macro undefined: the port and its logic are absent. All other behaviour is identical.
// STRUCTURE
//  - Package vga_timing_pkg holds the H_*/V_* defaults, H_TOT/V_TOT localparams, and the active-window
//    bounds (H_ACT_INI=48, H_ACT_FIN=688, V_ACT_INI=33, V_ACT_FIN=513). The colour stage shares these
//    constants.
//  - Sub-module vga_pix_tick contains the divider and the reset synchroniser and outputs pix_tick.
//    The counters and decode stay in this module.
// TESTING
//  1 Reset: hold resetM=0 for 10 clocks -> Qh=0, Qv=0, hsync=1, vsync=1, H_ON=0, V_ON=0.
//    After release, the first pix_tick arrives 4 clocks after sync and Qh becomes 1.
//  2 Line timing: measure hsync -> low for 96*4=384 clocks, period 3200 clocks.
//    H_ON rises exactly when Qh=48 and falls when Qh=688.
//  3 Frame timing: vsync low for 2 lines (6400 clocks), period 1,680,000 clocks.
//    V_ON is high for Qv 33..512. Qv increments only when Qh goes 799->0.
//  4 Wrap: at Qh=799 and Qv=524, the next pix_tick gives Qh=0, Qv=0 and vsync=1 on the same edge.
//    With the macro, fin_cuadro pulses for exactly 1 clock, once per frame.
//  5 Mid-frame reset: assert resetM at Qh=300, Qv=200 -> outputs go to reset values asynchronously,
//    before the next edge. The restart repeats scenario 1.
//  6 PIX_DIV=1 build: pix_tick is constant 1 and the line period is 800 clocks.
//    The active-region checks from scenario 2 still hold.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants shared by the sync generator and the colour stage.
// Optional frame-end pulse is enabled by defining VGA_SYNC_FRAME_TICK_EN.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned PIX_DIV_DEF = 4;

    localparam int unsigned H_BP_DEF  = 48;
    localparam int unsigned H_ACT_DEF = 640;
    localparam int unsigned H_FP_DEF  = 16;
    localparam int unsigned H_SYN_DEF = 96;

    localparam int unsigned V_BP_DEF  = 33;
    localparam int unsigned V_ACT_DEF = 480;
    localparam int unsigned V_FP_DEF  = 10;
    localparam int unsigned V_SYN_DEF = 2;

    localparam int unsigned H_TOT = H_BP_DEF + H_ACT_DEF + H_FP_DEF + H_SYN_DEF;
    localparam int unsigned V_TOT = V_BP_DEF + V_ACT_DEF + V_FP_DEF + V_SYN_DEF;

    localparam int unsigned H_ACT_INI = H_BP_DEF;
    localparam int unsigned H_ACT_FIN = H_BP_DEF + H_ACT_DEF;
    localparam int unsigned V_ACT_INI = V_BP_DEF;
    localparam int unsigned V_ACT_FIN = V_BP_DEF + V_ACT_DEF;

    typedef logic [CNT_W-1:0] cnt_t;

    // Half-open window test lo <= v < hi on an unsigned count.
    function automatic logic in_window(input cnt_t v, input int unsigned lo,
                                       input int unsigned hi);
        return (32'(v) >= lo) && (32'(v) < hi);
    endfunction

endpackage

// File: rtl/vga_pix_tick.sv
// Pixel-rate enable: synchronises reset release and divides the system clock by PIX_DIV.
// Shared by all builds; VGA_SYNC_FRAME_TICK_EN has no effect here.
module vga_pix_tick #(
    parameter int unsigned PIX_DIV = 4
) (
    input  logic reloj,
    input  logic resetM,
    output logic pix_tick
);

    localparam int unsigned DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(PIX_DIV - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             run_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             tick_q;
    logic             tick_d;

    // run_q delays counting by one clock so the first tick lands PIX_DIV clocks after sync.
    always_comb begin
        div_d = div_q;
        if (run_q) begin
            div_d = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
        end
        tick_d = sync_q2 && (div_d == DIV_MAX);
    end

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            run_q   <= 1'b0;
            div_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            sync_q1 <= 1'b1;
            sync_q2 <= sync_q1;
            run_q   <= sync_q2;
            div_q   <= div_d;
            tick_q  <= tick_d;
        end
    end

    assign pix_tick = tick_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: pixel/line counters, active-window flags and active-low sync pins.
// Define VGA_SYNC_FRAME_TICK_EN to add the fin_cuadro frame-end pulse.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned PIX_DIV = PIX_DIV_DEF,
    parameter int unsigned H_BP    = H_BP_DEF,
    parameter int unsigned H_ACT   = H_ACT_DEF,
    parameter int unsigned H_FP    = H_FP_DEF,
    parameter int unsigned H_SYN   = H_SYN_DEF,
    parameter int unsigned V_BP    = V_BP_DEF,
    parameter int unsigned V_ACT   = V_ACT_DEF,
    parameter int unsigned V_FP    = V_FP_DEF,
    parameter int unsigned V_SYN   = V_SYN_DEF
) (
    input  logic             reloj,
    input  logic             resetM,
    output logic             pix_tick,
    output logic [CNT_W-1:0] Qh,
    output logic [CNT_W-1:0] Qv,
    output logic             H_ON,
    output logic             V_ON,
    output logic             hsync,
`ifdef VGA_SYNC_FRAME_TICK_EN
    output logic             fin_cuadro,
`endif
    output logic             vsync
);

    localparam int unsigned HT = H_BP + H_ACT + H_FP + H_SYN;
    localparam int unsigned VT = V_BP + V_ACT + V_FP + V_SYN;
    localparam cnt_t        H_LAST = CNT_W'(HT - 1);
    localparam cnt_t        V_LAST = CNT_W'(VT - 1);

    cnt_t qh_q, qh_d;
    cnt_t qv_q, qv_d;
    logic h_on_q, h_on_d;
    logic v_on_q, v_on_d;
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;

    vga_pix_tick #(
        .PIX_DIV(PIX_DIV)
    ) u_pix_tick (
        .reloj   (reloj),
        .resetM  (resetM),
        .pix_tick(pix_tick)
    );

    // Flags decode the next-state counters so they switch on the same edge as Qh/Qv.
    always_comb begin
        qh_d = qh_q;
        qv_d = qv_q;
        if (pix_tick) begin
            if (qh_q == H_LAST) begin
                qh_d = '0;
                qv_d = (qv_q == V_LAST) ? '0 : qv_q + 1'b1;
            end else begin
                qh_d = qh_q + 1'b1;
            end
        end
        h_on_d  = in_window(qh_d, H_BP, H_BP + H_ACT);
        v_on_d  = in_window(qv_d, V_BP, V_BP + V_ACT);
        hsync_d = ~in_window(qh_d, HT - H_SYN, HT);
        vsync_d = ~in_window(qv_d, VT - V_SYN, VT);
    end

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            qh_q    <= '0;
            qv_q    <= '0;
            h_on_q  <= 1'b0;
            v_on_q  <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            qh_q    <= qh_d;
            qv_q    <= qv_d;
            h_on_q  <= h_on_d;
            v_on_q  <= v_on_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign Qh    = qh_q;
    assign Qv    = qv_q;
    assign H_ON  = h_on_q;
    assign V_ON  = v_on_q;
    assign hsync = hsync_q;
    assign vsync = vsync_q;

`ifdef VGA_SYNC_FRAME_TICK_EN
    assign fin_cuadro = pix_tick && (qh_q == H_LAST) && (qv_q == V_LAST);
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: default 640x480 timing plus a shrunken PIX_DIV=1 geometry.
// Honours VGA_SYNC_FRAME_TICK_EN when checking fin_cuadro.
module tb_vga_sync_gen;

    localparam int unsigned B_P    = 1;
    localparam int unsigned B_HBP  = 3;
    localparam int unsigned B_HACT = 8;
    localparam int unsigned B_HFP  = 2;
    localparam int unsigned B_HSYN = 3;
    localparam int unsigned B_VBP  = 2;
    localparam int unsigned B_VACT = 5;
    localparam int unsigned B_VFP  = 1;
    localparam int unsigned B_VSYN = 2;

    typedef struct {
        int unsigned p, hbp, hact, hfp, hsyn, vbp, vact, vfp, vsyn;
    } geom_t;

    typedef struct {
        int unsigned cyc;
        int unsigned pos;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic       tick_a, tick_b;
    logic [9:0] qh_a, qv_a, qh_b, qv_b;
    logic       hon_a, von_a, hs_a, vs_a, fin_a;
    logic       hon_b, von_b, hs_b, vs_b, fin_b;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   errors = 0;
    rec_t q_a[$];
    rec_t q_b[$];

    vga_sync_gen u_dut_a (
        .reloj     (clk),
        .resetM    (rst_a),
        .pix_tick  (tick_a),
        .Qh        (qh_a),
        .Qv        (qv_a),
        .H_ON      (hon_a),
        .V_ON      (von_a),
        .hsync     (hs_a),
`ifdef VGA_SYNC_FRAME_TICK_EN
        .fin_cuadro(fin_a),
`endif
        .vsync     (vs_a)
    );

    vga_sync_gen #(
        .PIX_DIV(B_P),
        .H_BP   (B_HBP),
        .H_ACT  (B_HACT),
        .H_FP   (B_HFP),
        .H_SYN  (B_HSYN),
        .V_BP   (B_VBP),
        .V_ACT  (B_VACT),
        .V_FP   (B_VFP),
        .V_SYN  (B_VSYN)
    ) u_dut_b (
        .reloj     (clk),
        .resetM    (rst_b),
        .pix_tick  (tick_b),
        .Qh        (qh_b),
        .Qv        (qv_b),
        .H_ON      (hon_b),
        .V_ON      (von_b),
        .hsync     (hs_b),
`ifdef VGA_SYNC_FRAME_TICK_EN
        .fin_cuadro(fin_b),
`endif
        .vsync     (vs_b)
    );

`ifndef VGA_SYNC_FRAME_TICK_EN
    assign fin_a = 1'b0;
    assign fin_b = 1'b0;
`endif

    function automatic geom_t geom(input int which);
        geom_t g;
        if (which == 0) begin
            g.p = 4; g.hbp = 48; g.hact = 640; g.hfp = 16; g.hsyn = 96;
            g.vbp = 33; g.vact = 480; g.vfp = 10; g.vsyn = 2;
        end else begin
            g.p = B_P; g.hbp = B_HBP; g.hact = B_HACT; g.hfp = B_HFP; g.hsyn = B_HSYN;
            g.vbp = B_VBP; g.vact = B_VACT; g.vfp = B_VFP; g.vsyn = B_VSYN;
        end
        return g;
    endfunction

    // Reference: the screen position after pos pixel ticks, decoded from the porch rules.
    function automatic logic [24:0] expect_vec(input geom_t g, input int unsigned pos);
        int unsigned ht, vt, qh, qv;
        logic hon, von, hs, vs, fin;
        ht  = g.hbp + g.hact + g.hfp + g.hsyn;
        vt  = g.vbp + g.vact + g.vfp + g.vsyn;
        qh  = pos % ht;
        qv  = (pos / ht) % vt;
        hon = (qh >= g.hbp) && (qh < g.hbp + g.hact);
        von = (qv >= g.vbp) && (qv < g.vbp + g.vact);
        hs  = !(qh >= ht - g.hsyn);
        vs  = !(qv >= vt - g.vsyn);
`ifdef VGA_SYNC_FRAME_TICK_EN
        fin = (qh == ht - 1) && (qv == vt - 1);
`else
        fin = 1'b0;
`endif
        return {10'(qh), 10'(qv), hon, von, hs, vs, fin};
    endfunction

    function automatic logic [24:0] actual_vec(input int which);
        if (which == 0) return {qh_a, qv_a, hon_a, von_a, hs_a, vs_a, fin_a};
        return {qh_b, qv_b, hon_b, von_b, hs_b, vs_b, fin_b};
    endfunction

    task automatic check_vec(input string name, input logic [24:0] act, input logic [24:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: {Qh,Qv,H_ON,V_ON,hs,vs,fin} got Qh=%0d Qv=%0d flags=%b, want Qh=%0d Qv=%0d flags=%b",
                     name, act[24:15], act[14:5], act[4:0], exp[24:15], exp[14:5], exp[4:0]);
        end
    endtask

    task automatic check_int(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic check_reset(input int which, input string name);
        logic t;
        t = (which == 0) ? tick_a : tick_b;
        check_vec(name, actual_vec(which), {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
        check_int({name, "_tick"}, 32'(t), 0);
    endtask

    // Releases reset, runs ncyc clocks, then asserts reset asynchronously mid-cycle.
    task automatic run_segment(input int which, input int unsigned ncyc);
        geom_t       g;
        int unsigned rel, last, done;
        rec_t        r;
        g = geom(which);
        @(negedge clk);
        #2;
        rel  = cyc;
        last = rel + ncyc;
        for (int unsigned k = 1; rel + 2 + k * g.p <= last; k++) begin
            r.cyc = rel + 2 + k * g.p;
            r.pos = k - 1;
            if (which == 0) q_a.push_back(r);
            else q_b.push_back(r);
        end
        if (which == 0) rst_a = 1'b1;
        else rst_b = 1'b1;
        while (cyc != last) @(negedge clk);
        #2;
        done = (ncyc >= 3) ? (ncyc - 3) / g.p : 0;
        check_vec((which == 0) ? "a_pre_reset" : "b_pre_reset", actual_vec(which),
                  expect_vec(g, done));
        if (which == 0) rst_a = 1'b0;
        else rst_b = 1'b0;
        #1;
        check_reset(which, (which == 0) ? "a_async_reset" : "b_async_reset");
        check_int((which == 0) ? "a_leftover" : "b_leftover",
                  (which == 0) ? q_a.size() : q_b.size(), 0);
        q_a.delete();
        q_b.delete();
        repeat ($urandom_range(2, 10)) @(negedge clk);
        #2;
        check_reset(which, (which == 0) ? "a_reset_hold" : "b_reset_hold");
    endtask

    always @(negedge clk) begin : mon_a
        rec_t r;
        if (tick_a === 1'b1) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_extra_tick: tick at cycle %0d, none expected", cyc);
            end else begin
                r = q_a.pop_front();
                check_int("a_tick_cycle", cyc, r.cyc);
                check_vec("a_state", actual_vec(0), expect_vec(geom(0), r.pos));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        rec_t r;
        if (tick_b === 1'b1) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_extra_tick: tick at cycle %0d, none expected", cyc);
            end else begin
                r = q_b.pop_front();
                check_int("b_tick_cycle", cyc, r.cyc);
                check_vec("b_state", actual_vec(1), expect_vec(geom(1), r.pos));
            end
        end
    end

    initial begin
        int unsigned tgt;
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        check_reset(0, "a_reset");
        check_reset(1, "b_reset");

        // Default timing: three full lines plus a random tail, then a short restart.
        run_segment(0, 3 * 3200 + $urandom_range(0, 3000));
        run_segment(0, $urandom_range(1, 4000));

        // Small geometry: several whole frames, then a reset at a random mid-frame position.
        run_segment(1, 3 * 160 + $urandom_range(0, 159));
        tgt = $urandom_range(0, 9) * 16 + $urandom_range(0, 15) + 160 * $urandom_range(0, 2);
        run_segment(1, 3 + tgt);
        for (int i = 0; i < 6; i++) begin
            run_segment(1, $urandom_range(1, 400));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
